// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared constants, read-beat type and byte parity helper for onchip_memory_dp
package onchip_mem_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_DATA_W = 256;

    typedef struct packed {
        logic                  valid;
        logic                  perr;
        logic [MAX_DATA_W-1:0] data;
    } rd_beat_t;

    // Even parity per byte: bit i is the XOR of byte i, so byte plus bit holds an even count of ones
    function automatic logic [MAX_DATA_W/BYTE_W-1:0] byte_parity(input logic [MAX_DATA_W-1:0] d);
        for (int i = 0; i < MAX_DATA_W / BYTE_W; i++)
            byte_parity[i] = ^d[i*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// onchip_mem_rd_pipe: per-port read valid/data chain of READ_LATENCY stages, frozen while clken is low
module onchip_mem_rd_pipe
    import onchip_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clken,
    input  rd_beat_t in_beat,
    output rd_beat_t out_beat
);

    rd_beat_t stage [READ_LATENCY];

    // Stage 0 is the RAM read register; a second stage acts as the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
        end else if (clken) begin
            stage[0] <= in_beat;
            for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_beat = stage[READ_LATENCY-1];

endmodule

// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp: true-dual-port RAM behind two Avalon-MM pipelined slaves; per-byte parity with ONCHIP_MEM_PARITY_EN
module onchip_memory_dp
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 70000,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "onchip_memory_dp.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic                clken,
`ifdef ONCHIP_MEM_PARITY_EN
    output logic                s1_parity_err,
    output logic                s2_parity_err,
`endif
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_write,
    input  logic                s1_read,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_collision,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_write,
    input  logic                s2_read,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_collision
);

    localparam int NB = DATA_W / BYTE_W;
`ifdef ONCHIP_MEM_PARITY_EN
    localparam int RAM_W = DATA_W + NB;
`else
    localparam int RAM_W = DATA_W;
`endif

    logic [RAM_W-1:0] mem [DEPTH];

    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][NB-1:0]     be;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             cs, wr, rd, acc, in_rng, we_req;
    rd_beat_t [1:0]         out_beat;
    logic                   coll_hit, s2_coll_q;
`ifdef ONCHIP_MEM_PARITY_EN
    logic [1:0][NB-1:0]     wpar;
`endif

    assign addr  = {s2_address, s1_address};
    assign be    = {s2_byteenable, s1_byteenable};
    assign wdata = {s2_writedata, s1_writedata};
    assign cs    = {s2_chipselect, s1_chipselect};
    assign wr    = {s2_write, s1_write};
    assign rd    = {s2_read, s1_read};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [RAM_W-1:0] word;
        logic             perr;
        rd_beat_t         in_beat;
        assign acc[p]    = cs[p] & (rd[p] | wr[p]) & clken & ~reset_req;
        assign in_rng[p] = 32'(addr[p]) < DEPTH;
        assign we_req[p] = acc[p] & wr[p] & in_rng[p];
        assign word      = in_rng[p] ? mem[addr[p]] : '0;
`ifdef ONCHIP_MEM_PARITY_EN
        logic [MAX_DATA_W/BYTE_W-1:0] wp_full, rp_full;
        assign wp_full = byte_parity(MAX_DATA_W'(wdata[p]));
        assign rp_full = byte_parity(MAX_DATA_W'(word[DATA_W-1:0]));
        assign wpar[p] = wp_full[NB-1:0];
        assign perr    = rp_full[NB-1:0] != word[RAM_W-1:DATA_W];
`else
        assign perr = 1'b0;
`endif
        // A write beats a simultaneous read on the same port, so only pure reads enter the pipe
        assign in_beat.valid = acc[p] & ~wr[p];
        assign in_beat.perr  = in_beat.valid & perr;
        assign in_beat.data  = in_beat.valid ? MAX_DATA_W'(word[DATA_W-1:0]) : '0;
        onchip_mem_rd_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_pipe (
            .clk      (clk),
            .reset    (reset),
            .clken    (clken),
            .in_beat  (in_beat),
            .out_beat (out_beat[p])
        );
    end

    // s2 loses when both ports commit to the same in-range word in the same cycle
    assign coll_hit = we_req[0] & we_req[1] & (addr[0] == addr[1]);

    // Byte-masked writes; reads in the same cycle see the pre-edge contents
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < NB; b++)
                if (we_req[p] && !(p == 1 && coll_hit) && be[p][b]) begin
                    mem[addr[p]][b*BYTE_W +: BYTE_W] <= wdata[p][b*BYTE_W +: BYTE_W];
`ifdef ONCHIP_MEM_PARITY_EN
                    mem[addr[p]][DATA_W+b] <= wpar[p][b];
`endif
                end
    end

    // One-cycle collision pulse following the dropped s2 write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) s2_coll_q <= 1'b0;
        else if (clken) s2_coll_q <= coll_hit;
    end

    assign s1_readdata      = out_beat[0].data[DATA_W-1:0];
    assign s1_readdatavalid = out_beat[0].valid;
    assign s1_collision     = 1'b0;
    assign s2_readdata      = out_beat[1].data[DATA_W-1:0];
    assign s2_readdatavalid = out_beat[1].valid;
    assign s2_collision     = s2_coll_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign s1_parity_err    = out_beat[0].perr;
    assign s2_parity_err    = out_beat[1].perr;
`endif

endmodule

// File: tb/tb_onchip_memory_dp.sv
// tb_onchip_memory_dp: directed bench; instance dut has READ_LATENCY=1, dut2 READ_LATENCY=2, both share stimulus
module tb_onchip_memory_dp;

    localparam int DEPTH = 70000;
    localparam int AW    = 17;

    logic          clk = 1'b0, reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
    logic [AW-1:0] s1_address, s2_address;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic          s1_chipselect, s1_write, s1_read, s2_chipselect, s2_write, s2_read;
    logic [31:0]   s1_writedata, s2_writedata;
    logic [31:0]   a1_data, a2_data, b1_data, b2_data;
    logic          a1_valid, a2_valid, a1_coll, a2_coll, b1_valid, b2_valid, b1_coll, b2_coll;
`ifdef ONCHIP_MEM_PARITY_EN
    logic          a1_perr, a2_perr, b1_perr, b2_perr;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    onchip_memory_dp #(.DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
`ifdef ONCHIP_MEM_PARITY_EN
        .s1_parity_err(a1_perr), .s2_parity_err(a2_perr),
`endif
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_write(s1_write), .s1_read(s1_read), .s1_writedata(s1_writedata),
        .s1_readdata(a1_data), .s1_readdatavalid(a1_valid), .s1_collision(a1_coll),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_write(s2_write), .s2_read(s2_read), .s2_writedata(s2_writedata),
        .s2_readdata(a2_data), .s2_readdatavalid(a2_valid), .s2_collision(a2_coll)
    );

    onchip_memory_dp #(.DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
`ifdef ONCHIP_MEM_PARITY_EN
        .s1_parity_err(b1_perr), .s2_parity_err(b2_perr),
`endif
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_write(s1_write), .s1_read(s1_read), .s1_writedata(s1_writedata),
        .s1_readdata(b1_data), .s1_readdatavalid(b1_valid), .s1_collision(b1_coll),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_write(s2_write), .s2_read(s2_read), .s2_writedata(s2_writedata),
        .s2_readdata(b2_data), .s2_readdatavalid(b2_valid), .s2_collision(b2_coll)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_write = 0; s1_read = 0; s1_address = '0; s1_writedata = '0; s1_byteenable = 4'hF;
        s2_chipselect = 0; s2_write = 0; s2_read = 0; s2_address = '0; s2_writedata = '0; s2_byteenable = 4'hF;
    endtask

    task automatic drive1(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        s1_chipselect = 1; s1_write = w; s1_read = r; s1_address = a; s1_writedata = d; s1_byteenable = be;
    endtask

    task automatic drive2(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        s2_chipselect = 1; s2_write = w; s2_read = r; s2_address = a; s2_writedata = d; s2_byteenable = be;
    endtask

    task automatic test_reset();
        idle();
        #1;
        checks++; if ({a1_data, a2_data, a1_valid, a2_valid, a1_coll, a2_coll} !== 70'd0) begin failures++; $display("FAIL reset_l1: outs=%h want 0", {a1_data, a2_data, a1_valid, a2_valid, a1_coll, a2_coll}); end
        checks++; if ({b1_data, b2_data, b1_valid, b2_valid, b1_coll, b2_coll} !== 70'd0) begin failures++; $display("FAIL reset_l2: outs=%h want 0", {b1_data, b2_data, b1_valid, b2_valid, b1_coll, b2_coll}); end
`ifdef ONCHIP_MEM_PARITY_EN
        checks++; if ({a1_perr, a2_perr, b1_perr, b2_perr} !== 4'd0) begin failures++; $display("FAIL reset_perr: got %b want 0000", {a1_perr, a2_perr, b1_perr, b2_perr}); end
`endif
        cyc(); cyc();
        reset = 0;
        cyc(); cyc();
        checks++; if ({a1_valid, a2_valid, a1_coll, a2_coll, b1_valid, b2_valid, b1_coll, b2_coll} !== 8'd0) begin failures++; $display("FAIL idle: flags=%b want 0", {a1_valid, a2_valid, a1_coll, a2_coll, b1_valid, b2_valid, b1_coll, b2_coll}); end
    endtask

    task automatic test_write_read();
        drive1(1, 0, 5, 32'hDEADBEEF, 4'hF);
        cyc();
        drive1(0, 1, 5, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_l1: valid=%b data=%h want 1 deadbeef", a1_valid, a1_data); end
        checks++; if (b1_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_l2_early: valid=%b want 0", b1_valid); end
        cyc();
        checks++; if (a1_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_l1_single: valid=%b want 0", a1_valid); end
        checks++; if (b1_valid !== 1'b1 || b1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_l2: valid=%b data=%h want 1 deadbeef", b1_valid, b1_data); end
        cyc();
        checks++; if (b1_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_l2_single: valid=%b want 0", b1_valid); end
    endtask

    task automatic test_byteenable();
        drive2(1, 0, 5, 32'h11223344, 4'b0101);
        cyc();
        drive2(0, 1, 5, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a2_valid !== 1'b1 || a2_data !== 32'hDE22BE44) begin failures++; $display("FAIL byteen: valid=%b data=%h want 1 de22be44", a2_valid, a2_data); end
        cyc();
    endtask

    task automatic test_collision();
        drive1(1, 0, 9, 32'hA, 4'hF);
        drive2(1, 0, 9, 32'hB, 4'hF);
        cyc();
        idle();
        checks++; if (a2_coll !== 1'b1 || a1_coll !== 1'b0 || b2_coll !== 1'b1) begin failures++; $display("FAIL coll_pulse: s1=%b s2=%b s2_l2=%b want 0 1 1", a1_coll, a2_coll, b2_coll); end
        cyc();
        checks++; if (a2_coll !== 1'b0 || b2_coll !== 1'b0) begin failures++; $display("FAIL coll_once: s2=%b s2_l2=%b want 0 0", a2_coll, b2_coll); end
        drive2(0, 1, 9, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a2_valid !== 1'b1 || a2_data !== 32'hA) begin failures++; $display("FAIL coll_winner: valid=%b data=%h want 1 0000000a", a2_valid, a2_data); end
        cyc();
    endtask

    task automatic test_read_during_write();
        drive1(0, 1, 9, 0, 4'hF);
        drive2(1, 0, 9, 32'hC, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hA) begin failures++; $display("FAIL rdw_old: valid=%b data=%h want 1 0000000a", a1_valid, a1_data); end
        checks++; if (a2_coll !== 1'b0 || a2_valid !== 1'b0) begin failures++; $display("FAIL rdw_s2: coll=%b valid=%b want 0 0", a2_coll, a2_valid); end
        drive1(0, 1, 9, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hC) begin failures++; $display("FAIL rdw_new: valid=%b data=%h want 1 0000000c", a1_valid, a1_data); end
        cyc();
    endtask

    task automatic test_out_of_range();
        drive1(1, 0, 17'(DEPTH), 32'h55, 4'hF);
        drive2(1, 0, 17'(DEPTH - 1), 32'h77, 4'hF);
        cyc();
        idle();
        drive1(0, 1, 17'(DEPTH), 0, 4'hF);
        drive2(0, 1, 17'(DEPTH - 1), 0, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'h0) begin failures++; $display("FAIL oor_read: valid=%b data=%h want 1 00000000", a1_valid, a1_data); end
        checks++; if (a2_valid !== 1'b1 || a2_data !== 32'h77) begin failures++; $display("FAIL last_word: valid=%b data=%h want 1 00000077", a2_valid, a2_data); end
        cyc();
    endtask

    task automatic test_clken();
        drive1(0, 1, 5, 0, 4'hF);
        cyc();
        idle();
        clken = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (b1_valid !== 1'b0 || a1_valid !== 1'b1) begin failures++; $display("FAIL clken_hold%0d: l2=%b l1=%b want 0 1", i, b1_valid, a1_valid); end
        end
        clken = 1;
        cyc();
        checks++; if (b1_valid !== 1'b1 || b1_data !== 32'hDE22BE44 || a1_valid !== 1'b0) begin failures++; $display("FAIL clken_resume: l2=%b data=%h l1=%b want 1 de22be44 0", b1_valid, b1_data, a1_valid); end
        cyc();
        checks++; if (b1_valid !== 1'b0) begin failures++; $display("FAIL clken_single: valid=%b want 0", b1_valid); end
    endtask

    task automatic test_reset_req();
        reset_req = 1;
        drive1(1, 0, 5, 32'h0, 4'hF);
        cyc();
        drive1(0, 1, 5, 0, 4'hF);
        cyc();
        checks++; if (a1_valid !== 1'b0) begin failures++; $display("FAIL rreq_block: valid=%b want 0", a1_valid); end
        reset_req = 0;
        cyc();
        idle();
        reset_req = 1;
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hDE22BE44) begin failures++; $display("FAIL rreq_nowrite: valid=%b data=%h want 1 de22be44", a1_valid, a1_data); end
        cyc();
        checks++; if (b1_valid !== 1'b1 || b1_data !== 32'hDE22BE44) begin failures++; $display("FAIL rreq_drain: valid=%b data=%h want 1 de22be44", b1_valid, b1_data); end
        reset_req = 0;
        cyc();
    endtask

    task automatic test_back_to_back();
        drive1(0, 1, 5, 0, 4'hF);
        cyc();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hDE22BE44) begin failures++; $display("FAIL b2b_0: valid=%b data=%h want 1 de22be44", a1_valid, a1_data); end
        drive1(0, 1, 9, 0, 4'hF);
        cyc();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hC || b1_valid !== 1'b1 || b1_data !== 32'hDE22BE44) begin failures++; $display("FAIL b2b_1: l1=%b %h l2=%b %h want 1 c 1 de22be44", a1_valid, a1_data, b1_valid, b1_data); end
        drive1(0, 1, 17'(DEPTH - 1), 0, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'h77 || b1_valid !== 1'b1 || b1_data !== 32'hC) begin failures++; $display("FAIL b2b_2: l1=%b %h l2=%b %h want 1 77 1 c", a1_valid, a1_data, b1_valid, b1_data); end
        cyc();
        checks++; if (a1_valid !== 1'b0 || b1_valid !== 1'b1 || b1_data !== 32'h77) begin failures++; $display("FAIL b2b_3: l1=%b l2=%b %h want 0 1 77", a1_valid, b1_valid, b1_data); end
        cyc();
    endtask

`ifdef ONCHIP_MEM_PARITY_EN
    task automatic test_parity();
        drive1(1, 0, 3, 32'h0F0F0F0F, 4'hF);
        cyc();
        idle();
        dut.mem[3][0]  = ~dut.mem[3][0];
        dut2.mem[3][0] = ~dut2.mem[3][0];
        drive1(0, 1, 3, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_perr !== 1'b1 || a1_data !== 32'h0F0F0F0E) begin failures++; $display("FAIL perr_l1: valid=%b perr=%b data=%h want 1 1 0f0f0f0e", a1_valid, a1_perr, a1_data); end
        cyc();
        checks++; if (b1_valid !== 1'b1 || b1_perr !== 1'b1 || a1_perr !== 1'b0) begin failures++; $display("FAIL perr_l2: valid=%b perr=%b l1perr=%b want 1 1 0", b1_valid, b1_perr, a1_perr); end
        drive2(0, 1, 5, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a2_valid !== 1'b1 || a2_perr !== 1'b0 || a2_data !== 32'hDE22BE44) begin failures++; $display("FAIL perr_clean: valid=%b perr=%b data=%h want 1 0 de22be44", a2_valid, a2_perr, a2_data); end
        cyc();
    endtask
`endif

    task automatic test_reset_mid_read();
        drive1(0, 1, 5, 0, 4'hF);
        @(posedge clk);
        #1;
        idle();
        reset = 1;
        #1;
        checks++; if (a1_valid !== 1'b0 || b1_valid !== 1'b0) begin failures++; $display("FAIL rst_async: l1=%b l2=%b want 0 0", a1_valid, b1_valid); end
        cyc();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (a1_valid !== 1'b0 || b1_valid !== 1'b0) begin failures++; $display("FAIL rst_lost%0d: l1=%b l2=%b want 0 0", i, a1_valid, b1_valid); end
        end
        drive1(0, 1, 5, 0, 4'hF);
        cyc();
        idle();
        checks++; if (a1_valid !== 1'b1 || a1_data !== 32'hDE22BE44) begin failures++; $display("FAIL rst_keeps_mem: valid=%b data=%h want 1 de22be44", a1_valid, a1_data); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_collision();
        test_read_during_write();
        test_out_of_range();
        test_clken();
        test_reset_req();
        test_back_to_back();
`ifdef ONCHIP_MEM_PARITY_EN
        test_parity();
`endif
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded 100000");
        $fatal(1, "timeout");
    end

endmodule
